// File: rtl/pkt_arb_pkg.sv
// Shared types for the packet-atomic pipeline arbiter.
//   arb_state_e  : arbiter FSM state (idle / packet in flight)
//   beat_flags_t : per-beat status flags carried with the source index
//   src_w()      : width of the source index for a given requester count
package pkt_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } arb_state_e;

  // Status word sent down the pipeline is {beat_flags_t, src}.
  typedef struct packed {
    logic valid;
    logic last;
    logic abort;
  } beat_flags_t;

  localparam int unsigned FlagsW = 3;

  function automatic int unsigned src_w(input int unsigned n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/data_status_pipeline.sv
// Fixed-latency register pipeline for a data word plus a status word.
//   clk, rst   : clock, synchronous active-high reset
//   data_i     : data word in (stages are not reset)
//   status_i   : status word in (stages reset to zero)
//   data_o     : data word, PIPE_DEPTH cycles later
//   status_o   : status word, PIPE_DEPTH cycles later
module data_status_pipeline #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STATUS_W   = 4,
  parameter int unsigned PIPE_DEPTH = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [STATUS_W-1:0] status_i,
  output logic [DATA_W-1:0]   data_o,
  output logic [STATUS_W-1:0] status_o
);

  logic [DATA_W-1:0]   data_q   [PIPE_DEPTH];
  logic [STATUS_W-1:0] status_q [PIPE_DEPTH];

  always_ff @(posedge clk) begin
    data_q[0] <= data_i;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        status_q[i] <= '0;
      end
    end else begin
      status_q[0] <= status_i;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        status_q[i] <= status_q[i-1];
      end
    end
  end

  assign data_o   = data_q[PIPE_DEPTH-1];
  assign status_o = status_q[PIPE_DEPTH-1];

endmodule

// File: rtl/pkt_pipe_arbiter.sv
// Packet-atomic round-robin arbiter feeding one shared data/status pipeline.
// A granted source owns the pipeline until its last beat; a source that stalls
// mid-packet for TIMEOUT_CYC cycles gets an abort beat injected on its behalf
// and the rest of its packet is drained and dropped.
//   clk, rst    : clock, synchronous active-high reset
//   req_data_i  : per-requester beat data, requester i at [i*DATA_W +: DATA_W]
//   req_valid_i : per-requester beat valid
//   req_last_i  : per-requester end-of-packet, qualified by valid
//   req_ready_o : per-requester accept (registered state only)
//   data_o      : pipelined beat data (not reset)
//   valid_o     : pipelined beat valid
//   last_o      : pipelined end-of-packet
//   abort_o     : pipelined abort marker, only set together with last_o
//   src_o       : pipelined source index
module pkt_pipe_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned PIPE_DEPTH  = 1,
  parameter int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned SRC_W      = src_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]       data_o,
  output logic                    valid_o,
  output logic                    last_o,
  output logic                    abort_o,
  output logic [SRC_W-1:0]        src_o
);

  localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYC);
  localparam int unsigned STATUS_W = FlagsW + SRC_W;

  arb_state_e        state_q, state_d;
  logic [SRC_W-1:0]  gnt_q, gnt_d;
  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [N_REQ-1:0]  discard_q, discard_d;

  logic              found;
  logic [SRC_W-1:0]  idx;
  beat_flags_t       beat_flags;
  logic [SRC_W-1:0]  beat_src;
  logic [DATA_W-1:0] beat_data;
  logic [STATUS_W-1:0] status_out;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    stall_d     = stall_q;
    discard_d   = discard_q;
    req_ready_o = discard_q;  // discarding sources are drained in any state
    beat_flags  = '0;
    beat_src    = '0;
    beat_data   = '0;
    found       = 1'b0;
    idx         = '0;

    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (discard_q[i] && req_valid_i[i] && req_last_i[i]) begin
        discard_d[i] = 1'b0;
      end
    end

    unique case (state_q)
      StIdle: begin
        // Search starts just after the last winner.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
          idx = SRC_W'((ptr_q + k) % N_REQ);
          if (!found && req_valid_i[idx] && !discard_q[idx]) begin
            found   = 1'b1;
            gnt_d   = idx;
            ptr_d   = idx;
            stall_d = '0;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        req_ready_o[gnt_q] = 1'b1;
        if (req_valid_i[gnt_q]) begin
          // A beat arriving in the limit cycle wins over the timeout.
          beat_flags.valid = 1'b1;
          beat_flags.last  = req_last_i[gnt_q];
          beat_src         = gnt_q;
          beat_data        = req_data_i[gnt_q*DATA_W +: DATA_W];
          stall_d          = '0;
          if (req_last_i[gnt_q]) begin
            state_d = StIdle;
          end
        end else if (stall_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          beat_flags.valid   = 1'b1;
          beat_flags.last    = 1'b1;
          beat_flags.abort   = 1'b1;
          beat_src           = gnt_q;
          stall_d            = '0;
          discard_d[gnt_q]   = 1'b1;
          state_d            = StIdle;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      ptr_q     <= SRC_W'(N_REQ - 1);
      stall_q   <= '0;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      stall_q   <= stall_d;
      discard_q <= discard_d;
    end
  end

  data_status_pipeline #(
    .DATA_W     (DATA_W),
    .STATUS_W   (STATUS_W),
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .data_i   (beat_data),
    .status_i ({beat_flags, beat_src}),
    .data_o   (data_o),
    .status_o (status_out)
  );

  assign {valid_o, last_o, abort_o, src_o} = status_out;

endmodule

// File: tb/tb_pkt_pipe_arbiter.sv
module tb_pkt_pipe_arbiter;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned N_REQ       = 2;
  localparam int unsigned PIPE_DEPTH  = 1;
  localparam int unsigned TIMEOUT_CYC = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N_REQ*DATA_W-1:0] req_data  = '0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ-1:0]        req_last  = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       data_o;
  logic                    valid_o, last_o, abort_o;
  logic [0:0]              src_o;

  pkt_pipe_arbiter #(
    .DATA_W      (DATA_W),
    .N_REQ       (N_REQ),
    .PIPE_DEPTH  (PIPE_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_data_i  (req_data),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .last_o      (last_o),
    .abort_o     (abort_o),
    .src_o       (src_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       a;
    logic       s;
  } exp_t;

  typedef struct {
    exp_t e;
    int   c;
  } out_t;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  beat_t q0[$];
  beat_t q1[$];
  out_t  log_q[$];
  logic [1:0] take;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o === 1'b1) log_q.push_back('{e: '{d: data_o, l: last_o, a: abort_o, s: src_o[0]},
                                           c: cyc});
  end

  function automatic beat_t bt(input logic [7:0] d, input logic l);
    return '{v: 1'b1, d: d, l: l};
  endfunction

  function automatic beat_t gap();
    return '{v: 1'b0, d: 8'h00, l: 1'b0};
  endfunction

  function automatic exp_t ex(input logic [7:0] d, input logic l, input logic a, input logic s);
    return '{d: d, l: l, a: a, s: s};
  endfunction

  // Present the head of each source queue for the current cycle.
  task automatic present();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    if (q0.size() > 0) begin
      req_valid[0] = q0[0].v; req_last[0] = q0[0].l; req_data[7:0] = q0[0].d;
    end
    if (q1.size() > 0) begin
      req_valid[1] = q1[0].v; req_last[1] = q1[0].l; req_data[15:8] = q1[0].d;
    end
  endtask

  // Gaps always consume a cycle; real beats leave only when accepted.
  task automatic finish_cycle();
    @(negedge clk);
    take[0] = (q0.size() > 0) && (!q0[0].v || req_ready[0]);
    take[1] = (q1.size() > 0) && (!q1[0].v || req_ready[1]);
    @(posedge clk);
    #1;
    if (take[0]) void'(q0.pop_front());
    if (take[1]) void'(q1.pop_front());
  endtask

  task automatic drain(output bit done);
    for (int k = 0; k < 80 && (q0.size() > 0 || q1.size() > 0); k++) begin
      present();
      finish_cycle();
    end
    done = (q0.size() == 0) && (q1.size() == 0);
    repeat (3) begin
      present();
      finish_cycle();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b, want 00", req_ready);
    end
    n_checks++;
    if ({valid_o, last_o, abort_o, src_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_status: got %b, want 0000", {valid_o, last_o, abort_o, src_o});
    end
  endtask

  task automatic test_single_packet();
    logic [11:0] act, want;
    do_reset();
    req_valid = 2'b01;
    req_last  = 2'b00;
    req_data[7:0] = 8'h11;
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_fail++; $display("FAIL single_ready_pre: got %b, want 00", req_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL single_ready_grant: got %b, want 01", req_ready);
    end
    for (int b = 0; b < 4; b++) begin
      req_data[7:0] = 8'h11 + 8'(b);
      req_last[0]   = (b == 3);
      @(posedge clk); #1;
      act  = {valid_o, data_o, last_o, abort_o, src_o};
      want = {1'b1, 8'h11 + 8'(b), (b == 3), 1'b0, 1'b0};
      n_checks++;
      if (act !== want) begin
        n_fail++; $display("FAIL single_beat%0d: got %h, want %h", b, act, want);
      end
    end
    req_valid = '0;
    req_last  = '0;
    @(posedge clk); #1;
    n_checks++;
    if ({valid_o, req_ready} !== 3'b000) begin
      n_fail++; $display("FAIL single_idle: got %b, want 000", {valid_o, req_ready});
    end
  endtask

  task automatic test_round_robin();
    bit   done;
    exp_t exp_q[$];
    int   want_gap;
    do_reset();
    q0 = '{bt(8'h01, 0), bt(8'h02, 0), bt(8'h03, 1), bt(8'h04, 0), bt(8'h05, 0), bt(8'h06, 1)};
    q1 = '{bt(8'h81, 0), bt(8'h82, 0), bt(8'h83, 1), bt(8'h84, 0), bt(8'h85, 0), bt(8'h86, 1)};
    exp_q = '{ex(8'h01, 0, 0, 0), ex(8'h02, 0, 0, 0), ex(8'h03, 1, 0, 0),
              ex(8'h81, 0, 0, 1), ex(8'h82, 0, 0, 1), ex(8'h83, 1, 0, 1),
              ex(8'h04, 0, 0, 0), ex(8'h05, 0, 0, 0), ex(8'h06, 1, 0, 0),
              ex(8'h84, 0, 0, 1), ex(8'h85, 0, 0, 1), ex(8'h86, 1, 0, 1)};
    drain(done);
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL rr_drain: got stuck, want queues empty");
    end
    n_checks++;
    if (log_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rr_count: got %0d, want %0d", log_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      n_checks++;
      if (log_q[k].e !== exp_q[k]) begin
        n_fail++; $display("FAIL rr_beat%0d: got %h, want %h", k, log_q[k].e, exp_q[k]);
      end
      if (k > 0) begin
        want_gap = (k % 3 == 0) ? 2 : 1;
        n_checks++;
        if (log_q[k].c - log_q[k-1].c != want_gap) begin
          n_fail++;
          $display("FAIL rr_spacing%0d: got %0d, want %0d", k, log_q[k].c - log_q[k-1].c,
                   want_gap);
        end
      end
    end
  endtask

  // Watchdog abort, then the stalled source's tail is drained silently.
  task automatic test_watchdog_discard();
    bit   done;
    exp_t exp_q[$];
    do_reset();
    q0 = '{bt(8'h21, 0), bt(8'h22, 0), gap(), gap(), gap(), gap(), gap(), gap(),
           bt(8'h31, 0), bt(8'h32, 0), bt(8'h33, 1), bt(8'h51, 0), bt(8'h52, 1)};
    q1 = '{bt(8'h41, 0), bt(8'h42, 0), bt(8'h43, 1)};
    exp_q = '{ex(8'h21, 0, 0, 0), ex(8'h22, 0, 0, 0), ex(8'h00, 1, 1, 0),
              ex(8'h41, 0, 0, 1), ex(8'h42, 0, 0, 1), ex(8'h43, 1, 0, 1),
              ex(8'h51, 0, 0, 0), ex(8'h52, 1, 0, 0)};
    drain(done);
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL wd_drain: got stuck, want queues empty");
    end
    n_checks++;
    if (log_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL wd_count: got %0d, want %0d", log_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      n_checks++;
      if (log_q[k].e !== exp_q[k]) begin
        n_fail++; $display("FAIL wd_beat%0d: got %h, want %h", k, log_q[k].e, exp_q[k]);
      end
    end
    if (log_q.size() >= 3) begin
      n_checks++;
      if (log_q[2].c - log_q[1].c != 4) begin
        n_fail++; $display("FAIL wd_abort_delay: got %0d, want 4", log_q[2].c - log_q[1].c);
      end
    end
  endtask

  task automatic test_timeout_edge();
    bit   done;
    exp_t exp_q[$];
    do_reset();
    q0 = '{bt(8'h61, 0), gap(), gap(), gap(), bt(8'h62, 1)};
    exp_q = '{ex(8'h61, 0, 0, 0), ex(8'h62, 1, 0, 0)};
    drain(done);
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL edge_drain: got stuck, want queues empty");
    end
    n_checks++;
    if (log_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL edge_count: got %0d, want %0d", log_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      n_checks++;
      if (log_q[k].e !== exp_q[k]) begin
        n_fail++; $display("FAIL edge_beat%0d: got %h, want %h", k, log_q[k].e, exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit   done;
    bit   hit;
    exp_t exp_q[$];
    do_reset();
    q0 = '{bt(8'h81, 0), gap(), gap(), gap(), gap(), gap(), gap(), gap(), gap(), gap(), gap()};
    q1 = '{bt(8'h91, 0), bt(8'h92, 0), bt(8'h93, 0), bt(8'h94, 1)};
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      present();
      if (req_valid[1] && req_ready[1] && req_data[15:8] == 8'h92) hit = 1'b1;
      else finish_cycle();
    end
    n_checks++;
    if (!hit) begin
      n_fail++; $display("FAIL rst_find_beat2: got not found, want req1 beat 0x92 offered");
    end
    // Source 0 was aborted earlier, so it is being drained when reset lands.
    n_checks++;
    if (req_ready !== 2'b11) begin
      n_fail++; $display("FAIL rst_pre_ready: got %b, want 11", req_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({valid_o, req_ready} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_state: got %b, want 000", {valid_o, req_ready});
    end
    rst = 1'b0;
    q0.delete();
    q1.delete();
    log_q.delete();
    q0 = '{bt(8'hA1, 1)};
    q1 = '{bt(8'hB1, 1)};
    exp_q = '{ex(8'hA1, 1, 0, 0), ex(8'hB1, 1, 0, 1)};
    drain(done);
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL rst_drain: got stuck, want queues empty");
    end
    n_checks++;
    if (log_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rst_count: got %0d, want %0d", log_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      n_checks++;
      if (log_q[k].e !== exp_q[k]) begin
        n_fail++; $display("FAIL rst_beat%0d: got %h, want %h", k, log_q[k].e, exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_watchdog_discard();
    test_timeout_edge();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_pipe_arbiter.md
# pkt_pipe_arbiter

Packet-atomic round-robin arbiter that shares one byte-wide data/status pipeline among N_REQ upstream packet sources in the 1G Ethernet datapath, e.g. the RX parser output and locally generated control/pause frames. Each granted packet passes through whole. The source index travels with every beat through the pipeline so that downstream logic can demultiplex. A per-grant stall watchdog stops a stalled source from blocking the pipeline by aborting its packet and discarding the remainder.

## Interface
- DATA_W, 8: beat data width
- N_REQ, 2: number of requesters, 2..8
- PIPE_DEPTH, 1: register stages in the shared pipeline, ≥1
- TIMEOUT_CYC, 64: idle cycles allowed mid-packet before abort, ≥2
- clk  in  1  clock; one clock for the whole block
- rst  in  1  reset, synchronous, active-high
- req_data_i  in  N_REQ×DATA_W  per-requester beat data
- req_valid_i  in  N_REQ  per-requester beat valid
- req_last_i  in  N_REQ  per-requester end-of-packet marker, qualified by valid
- req_ready_o  out  N_REQ  per-requester accept
- data_o  out  DATA_W  pipelined beat data; not reset
- valid_o  out  1  pipelined beat valid; no backpressure
- last_o  out  1  pipelined end-of-packet
- abort_o  out  1  pipelined abort marker, valid only with last_o
- src_o  out  SRC_W=$clog2(N_REQ)  pipelined source index

## Operation
- FSM states: IDLE and BUSY. Registered state: grant index gnt, round-robin pointer ptr (the last granted index), stall counter, and per-requester discard flags.
- IDLE, eligibility: a requester is eligible when req_valid_i=1 and its discard flag is 0.
- IDLE, grant: if any requester is eligible, pick the first one searching ptr+1, ptr+2, … modulo N_REQ. Then gnt←winner, ptr←winner, and go to BUSY. No beat is accepted in IDLE.
- BUSY, ready: req_ready_o[gnt]=1; every other ready is 0 unless that requester's discard flag is set.
- BUSY, accepted beat: valid&ready is forwarded into the pipeline with status {valid=1, last, abort=0, src=gnt} and the stall counter is cleared.
- BUSY, last beat: an accepted beat with last=1 returns the FSM to IDLE.
- BUSY, stall: while req_valid_i[gnt]=0 the stall counter increments.
- BUSY, timeout: when the counter reaches TIMEOUT_CYC-1 with valid still low:
  - inject an abort beat {valid=1, last=1, abort=1, src=gnt, data=0};
  - set discard[gnt];
  - go to IDLE.
- Simultaneous valid and timeout: if valid returns in the same cycle the counter would reach the limit, the beat is accepted and no abort occurs.
- Discard flag behaviour: while set, that requester's ready=1 and its beats are dropped with no output. An accepted beat with last=1 clears the flag. The requester is not eligible for grant while its flag is set.
- Pipeline status: the status word is {valid, last, abort, src}, width 3+SRC_W, and its pipeline registers reset to 0. The data stages are not reset.
- Cycles with no accepted beat push status valid=0 into the pipeline.

## Timing
- Grant latency: eligible valid in IDLE at cycle t → ready at t+1, first beat accepted at t+1 at the earliest.
- Back-to-back packets: a last beat accepted at t → IDLE at t+1 → next grant at t+1 → next accept at t+2. This is one bubble per packet.
- Data latency: a beat accepted (or abort beat injected) at cycle t appears on the outputs at t+PIPE_DEPTH.
- Reset, the cycle after rst is sampled high:
  - state=IDLE, ptr=N_REQ-1 (requester 0 wins first), stall counter=0, discard flags=0, all req_ready_o=0;
  - pipeline status registers are 0, so valid_o, last_o, abort_o and src_o all read 0.
- Reset mid-packet: the packet is truncated silently with no abort beat. Beats already in the pipeline are lost.
- Ready is a function of registered state only; there is no combinational path from req_valid_i to req_ready_o.

## Structure
- Package pkt_arb_pkg:
  - state enum {IDLE, BUSY};
  - packed status struct {valid, last, abort, src};
  - SRC_W function.
- Sub-module: one instance of the existing data_status_pipeline, with DATA_W=DATA_W, STATUS_W=3+SRC_W, PIPE_DEPTH=PIPE_DEPTH.
- Arbitration, watchdog and discard logic live in this module.

## Test plan
- Single packet, N_REQ=2, PIPE_DEPTH=1: req0 sends 4 beats 0x11..0x14 → ready0 rises one cycle after valid. Output shows 4 beats at accept+1 with src=0, last on 0x14, abort=0.
- Round robin: req0 and req1 both hold 3-beat packets continuously → output order is 0,1,0,1. There is exactly one idle cycle between packets, and no interleaving within a packet.
- Watchdog, TIMEOUT_CYC=4: req0 sends 2 beats then drops valid → after 4 stalled cycles one output beat with last=1, abort=1, data=0, src=0. A pending req1 packet is granted next.
- Discard: continuing the watchdog scenario, req0 resumes with 3 beats, last on the third → ready0=1 and no output for those beats. After that req0 is eligible again and its next packet is forwarded normally.
- Valid returns at the timeout edge: the granted requester reasserts valid in the limit cycle → the beat is accepted and no abort beat appears.
- Reset mid-packet: rst asserted for 1 cycle during req1 beat 2 → next cycle valid_o=0 and all ready=0, discard flags clear. req0 then wins the first grant.
